acq_scheduler: RTL and testbench

ACQ_SCHEDULER -- requirements
Module: acq_scheduler

---
 rtl/acq_scheduler_pkg.sv | 26 ++
 rtl/sec_prescaler.sv | 29 ++
 rtl/acq_scheduler.sv | 132 +++++++++++++
 tb/tb_acq_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_scheduler_pkg.sv
// Shared types and constants for the acquisition scheduler: FSM encoding,
// frame timestamp layout and counter limits.
package acq_scheduler_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      START,
      BUSY,
      HOLD
   } state_t;

   typedef struct packed {
      logic       epoch;
      logic [5:0] min;
      logic [5:0] sec;
   } frame_ts_t;

   localparam logic [3:0] MISSED_MAX = 4'd15;

   // A programmed period of zero behaves as one second.
   function automatic logic [5:0] period_load(input logic [5:0] p);
      return (p == 6'd0) ? 6'd1 : p;
   endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-cycle sec_tick every CLK_PER_SEC cycles while
// enabled; parked at zero when disabled.
module sec_prescaler #(
   parameter int CLK_PER_SEC = 10_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic sec_tick
);

   localparam int            CW   = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_SEC - 1);

   logic [CW-1:0] count;

   // NOTE: clocked state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (!enable || count == LAST)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   assign sec_tick = enable && !reset && (count == LAST);

endmodule

// File: rtl/acq_scheduler.sv
// Periodic frame acquisition scheduler: starts the extractor every period
// seconds, time-stamps each frame and hands the record to a consumer.
module acq_scheduler
   import acq_scheduler_pkg::*;
#(
   parameter int CLK_PER_SEC = 10_000_000,
   parameter int BUSY_TMO    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [5:0]  period,
   input  logic [5:0]  sec,
   input  logic [5:0]  min,
   input  logic        ovf,
   output logic        sec_tick,
   output logic        rst_ovf,
   output logic        ext_start,
   input  logic        ext_done,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic [12:0] frame_ts,
   output logic [7:0]  frame_cnt,
   output logic [3:0]  missed_cnt,
   output logic        tmo_err
);

   localparam int            TW       = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);

   state_t        state;
   logic [5:0]    per_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          epoch;
   logic          ovf_defer;
   logic          frame_due;
   logic          ovf_req;
   frame_ts_t     ts_q;

   sec_prescaler #(.CLK_PER_SEC(CLK_PER_SEC)) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .sec_tick (sec_tick)
   );

   assign frame_due = sec_tick && (per_cnt == 6'd1);
   assign ovf_req   = (ovf || ovf_defer) && !rst_ovf;
   assign frame_ts  = ts_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         per_cnt     <= '0;
         tmo_cnt     <= '0;
         epoch       <= 1'b0;
         ovf_defer   <= 1'b0;
         rst_ovf     <= 1'b0;
         ext_start   <= 1'b0;
         frame_valid <= 1'b0;
         ts_q        <= '0;
         frame_cnt   <= '0;
         missed_cnt  <= '0;
         tmo_err     <= 1'b0;
      end else begin
         // NOTE: one-cycle pulses default low here; branches below raise them.
         rst_ovf   <= 1'b0;
         ext_start <= 1'b0;

         if (state == IDLE && enable)
            per_cnt <= period_load(period);
         else if (frame_due)
            per_cnt <= period_load(period);
         else if (sec_tick)
            per_cnt <= per_cnt - 6'd1;

         if (frame_due && (state == START || state == BUSY || state == HOLD) &&
             missed_cnt != MISSED_MAX)
            missed_cnt <= missed_cnt + 4'd1;

         // An overflow landing on the capture cycle waits one cycle so the
         // captured epoch is the one in force when the frame started.
         if (ovf_req) begin
            if (state == START) begin
               ovf_defer <= 1'b1;
            end else begin
               rst_ovf   <= 1'b1;
               epoch     <= ~epoch;
               ovf_defer <= 1'b0;
            end
         end

         unique case (state)
            IDLE:
               if (enable) state <= ARMED;
            ARMED:
               if (!enable) begin
                  state <= IDLE;
               end else if (frame_due) begin
                  state     <= START;
                  ext_start <= 1'b1;
               end
            START: begin
               ts_q    <= '{epoch, min, sec};
               tmo_cnt <= '0;
               state   <= BUSY;
            end
            BUSY:
               if (ext_done) begin
                  state       <= HOLD;
                  frame_valid <= 1'b1;
               end else if (sec_tick) begin
                  if (tmo_cnt == TMO_LAST) begin
                     tmo_err <= 1'b1;
                     state   <= ARMED;
                  end else begin
                     tmo_cnt <= tmo_cnt + 1'b1;
                  end
               end
            HOLD:
               if (frame_ready) begin
                  frame_valid <= 1'b0;
                  frame_cnt   <= frame_cnt + 8'd1;
                  state       <= enable ? ARMED : IDLE;
               end
            default:
               state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acq_scheduler.sv
// Self-checking bench for acq_scheduler: table-driven start-up vectors,
// directed corner sequences and randomized frames against an edge-time model.
module tb_acq_scheduler;

   localparam int CPS  = 4;
   localparam int TMO  = 4;
   localparam int T_EN = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [5:0]  period = '0;
   logic [5:0]  sec = '0;
   logic [5:0]  min = '0;
   logic        ovf = 1'b0;
   logic        ext_done = 1'b0;
   logic        frame_ready = 1'b0;
   logic        sec_tick, rst_ovf, ext_start, frame_valid, tmo_err;
   logic [12:0] frame_ts;
   logic [7:0]  frame_cnt;
   logic [3:0]  missed_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   acq_scheduler #(.CLK_PER_SEC(CPS), .BUSY_TMO(TMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .period      (period),
      .sec         (sec),
      .min         (min),
      .ovf         (ovf),
      .sec_tick    (sec_tick),
      .rst_ovf     (rst_ovf),
      .ext_start   (ext_start),
      .ext_done    (ext_done),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_ts    (frame_ts),
      .frame_cnt   (frame_cnt),
      .missed_cnt  (missed_cnt),
      .tmo_err     (tmo_err)
   );

   always #5 clk = ~clk;

   // Edge index since reset release: edge 1 is the first rising edge after it.
   always @(posedge clk or posedge reset)
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;

   typedef struct {
      logic       en, done, rdy;
      logic       tick, start, valid;
      logic [7:0] fcnt;
   } vec_t;

   vec_t vtab[30];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_sec_tick"},    32'(sec_tick),    0);
      check({tag, "_rst_ovf"},     32'(rst_ovf),     0);
      check({tag, "_ext_start"},   32'(ext_start),   0);
      check({tag, "_frame_valid"}, 32'(frame_valid), 0);
      check({tag, "_frame_ts"},    32'(frame_ts),    0);
      check({tag, "_frame_cnt"},   32'(frame_cnt),   0);
      check({tag, "_missed_cnt"},  32'(missed_cnt),  0);
      check({tag, "_tmo_err"},     32'(tmo_err),     0);
   endtask

   task automatic do_reset();
      enable = 1'b0; ext_done = 1'b0; frame_ready = 1'b0; ovf = 1'b0;
      period = '0; sec = '0; min = '0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_start(input int limit);
      int n = 0;
      while (!ext_start && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("start_seen", 32'(ext_start), 1);
   endtask

   // Second boundaries fall on edges T_EN + CPS*k - 1; frames fall due every p of them.
   function automatic int due_after(input int e, input int p);
      int m = 1;
      while (T_EN + CPS * p * m - 1 <= e) m++;
      return T_EN + CPS * p * m - 1;
   endfunction

   function automatic int dues_in(input int lo, input int hi, input int p);
      int n = 0;
      for (int e = due_after(lo - 1, p); e <= hi; e += CPS * p) n++;
      return n;
   endfunction

   // fix_d/fix_r < 0 pick random extractor latency / consumer stall per frame.
   task automatic run_frames(input int per, input int nfr, input int fix_d, input int fix_r);
      int p, prev_end, s, d, a, t4, fin, k, mc, fc, dd, rr;
      logic timed, tmo, in_hold, spur;
      logic [12:0] ts;
      do_reset();
      p = (per == 0) ? 1 : per;
      period = 6'(per);
      enable = 1'b1;
      prev_end = T_EN; mc = 0; fc = 0; tmo = 1'b0; ts = '0;
      for (int f = 0; f < nfr; f++) begin
         s = due_after(prev_end, p);
         do begin
            sec = 6'($urandom_range(59, 0));
            min = 6'($urandom_range(59, 0));
            frame_ready = 1'($urandom);
            ext_done = 1'($urandom);
            @(negedge clk);
         end while (!ext_start && cyc < s + 8);
         check("start_edge", 32'(cyc), 32'(s));
         s = cyc;
         dd = (fix_d > 0) ? fix_d : int'($urandom_range(22, 1));
         rr = (fix_r >= 0) ? fix_r : int'($urandom_range(4, 0));
         d = s + 1 + dd;
         k = 1;
         while (T_EN + CPS * k - 1 < s + 2) k++;
         t4 = T_EN + CPS * (k + TMO - 1) - 1;
         timed = (t4 < d);
         a = d + 1 + rr;
         fin = timed ? t4 : a;
         for (int c = s; c < fin; c++) begin
            sec = 6'($urandom_range(59, 0));
            min = 6'($urandom_range(59, 0));
            if (c == s) ts = {1'b0, min, sec};
            spur = (c == s) || (!timed && c + 1 > d);
            ext_done = (!timed && c + 1 == d) || (spur && 1'($urandom));
            if (!timed && c + 1 > d) frame_ready = (c + 1 == a);
            else                     frame_ready = 1'($urandom);
            @(negedge clk);
            in_hold = !timed && cyc >= d && cyc < a;
            check("ext_start_in_frame", 32'(ext_start), 0);
            check("frame_valid", 32'(frame_valid), 32'(in_hold));
            if (in_hold) check("frame_ts", 32'(frame_ts), 32'(ts));
            check("tmo_err", 32'(tmo_err), 32'(tmo || (timed && cyc >= t4)));
         end
         ext_done = 1'b0;
         mc = (mc + dues_in(s + 1, fin, p) > 15) ? 15 : mc + dues_in(s + 1, fin, p);
         if (!timed) fc++;
         tmo = tmo || timed;
         check("frame_cnt", 32'(frame_cnt), 32'(fc % 256));
         check("missed_cnt", 32'(missed_cnt), 32'(mc));
         prev_end = fin;
      end
   endtask

   initial begin
      // Start-up with period=2, extractor done 3 cycles after start, consumer always ready.
      for (int i = 0; i < 30; i++) begin
         vtab[i].en    = 1'b1;
         vtab[i].done  = (i == 11) || (i == 19) || (i == 27);
         vtab[i].rdy   = 1'b1;
         vtab[i].tick  = ((i + 1) % 4 == 3);
         vtab[i].start = (i + 1 == 8) || (i + 1 == 16) || (i + 1 == 24);
         vtab[i].valid = (i + 1 == 12) || (i + 1 == 20) || (i + 1 == 28);
         vtab[i].fcnt  = (i + 1 >= 29) ? 8'd3 : (i + 1 >= 21) ? 8'd2 : (i + 1 >= 13) ? 8'd1 : 8'd0;
      end

      do_reset();
      check_zero("reset");

      period = 6'd2;
      for (int i = 0; i < 30; i++) begin
         enable = vtab[i].en; ext_done = vtab[i].done; frame_ready = vtab[i].rdy;
         @(negedge clk);
         check("tab_sec_tick",    32'(sec_tick),    32'(vtab[i].tick));
         check("tab_ext_start",   32'(ext_start),   32'(vtab[i].start));
         check("tab_frame_valid", 32'(frame_valid), 32'(vtab[i].valid));
         check("tab_frame_cnt",   32'(frame_cnt),   32'(vtab[i].fcnt));
      end

      // Overflow: first pulse lands on a START cycle, second on an ARMED cycle.
      do_reset();
      period = 6'd1; enable = 1'b1; frame_ready = 1'b1; min = 6'd59; sec = 6'd59;
      for (int i = 0; i < 16; i++) begin
         ovf = (i == 4) || (i == 11);
         ext_done = (i == 5) || (i == 9) || (i == 13);
         @(negedge clk);
         check("rst_ovf", 32'(rst_ovf), 32'((cyc == 6) || (cyc == 12)));
         check("ovf_frame_valid", 32'(frame_valid), 32'((cyc == 6) || (cyc == 10) || (cyc == 14)));
         if (cyc == 6)  check("ts_deferred_epoch", 32'(frame_ts), 32'h0EFB);
         if (cyc == 10) check("ts_new_epoch",      32'(frame_ts), 32'h1EFB);
         if (cyc == 14) check("ts_toggled_back",   32'(frame_ts), 32'h0EFB);
      end
      ovf = 1'b0;

      // Consumer stall in HOLD, then enable dropped while holding.
      do_reset();
      period = 6'd1; enable = 1'b1; sec = 6'd5; min = 6'd7;
      for (int i = 0; i < 16; i++) begin
         ext_done = (i == 5);
         @(negedge clk);
         if (cyc >= 6) begin
            check("hold_valid", 32'(frame_valid), 1);
            check("hold_ts",    32'(frame_ts),    32'h01C5);
            check("hold_cnt",   32'(frame_cnt),   0);
         end
      end
      check("hold_missed", 32'(missed_cnt), 3);
      enable = 1'b0; frame_ready = 1'b1;
      @(negedge clk);
      check("accept_cnt",   32'(frame_cnt),   1);
      check("accept_valid", 32'(frame_valid), 0);
      frame_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("idle_no_start", 32'(ext_start), 0);
      end

      // Enable falls on the START cycle: the frame still completes.
      enable = 1'b1;
      wait_start(12);
      enable = 1'b0;
      @(negedge clk);
      ext_done = 1'b1;
      @(negedge clk);
      ext_done = 1'b0;
      check("drop_en_valid", 32'(frame_valid), 1);
      frame_ready = 1'b1;
      @(negedge clk);
      check("drop_en_cnt",   32'(frame_cnt),   2);
      check("drop_en_valid_clr", 32'(frame_valid), 0);
      frame_ready = 1'b0;

      // Asynchronous reset while BUSY.
      enable = 1'b1; sec = 6'd9; min = 6'd33;
      wait_start(12);
      repeat (2) @(negedge clk);
      check("busy_ts", 32'(frame_ts), 32'h0849);
      #2 reset = 1'b1;
      #1 check_zero("async_reset");
      repeat (2) @(negedge clk);
      enable = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ext_done = (i == 3);
         frame_ready = 1'b1;
         @(negedge clk);
         check("post_reset_start", 32'(ext_start),   0);
         check("post_reset_valid", 32'(frame_valid), 0);
         check("post_reset_cnt",   32'(frame_cnt),   0);
      end

      run_frames(2, 2, 40, 0);
      run_frames(1, 10, 6, 0);
      for (int r = 0; r < 6; r++) run_frames(int'($urandom_range(3, 0)), 12, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
